cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus (CDB) between NREQ execution-unit requesters, e.g. integer ALU, multiplier, divider and load/store address unit.
- Uses round-robin arbitration and drives the CDB broadcast (valid, ROB tag, physical destination, data, store address) consumed by the ROB, issue queues and register file.
- Squashes broadcasts younger than a mispredicted branch during a flush.

Parameters:
NREQ, 4, number of requesting execution units (2..8)
SW, $clog2(NREQ), width of winner index (derived; not overridden)

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
req_val  in  NREQ  requester i has a result ready; held until granted
req_robtag  in  NREQ*5  ROB tag per requester, slice i = [5*i+4:5*i]
req_phy_addr  in  NREQ*6  destination physical register per requester
req_data  in  NREQ*32  result data per requester
req_swaddr  in  NREQ*32  store word address per requester (don't-care for non-stores)
req_gnt  out  NREQ  one-hot grant, combinational, same cycle as req_val
rob_rdptr  in  6  ROB head pointer; bits [4:0] used for age compare
cdb_flush  in  1  branch misprediction flush this cycle
cfc_robtag  in  5  ROB tag of the mispredicted branch
cdb_val  out  1  CDB broadcast valid
cdb_robtag  out  5  broadcast ROB tag
cdb_phy_addr  out  6  broadcast physical destination
cdb_data  out  32  broadcast data
cdb_swaddr  out  32  broadcast store address
cdb_src  out  SW  index of requester that owns the current broadcast

Behaviour:
- Reset (rst_b low, async):
  - cdb_val=0; cdb_robtag, cdb_phy_addr, cdb_data, cdb_swaddr and cdb_src = 0.
  - Round-robin pointer rr_ptr=0.
  - req_gnt=0 while rst_b is low.
  - Deassertion is synchronous to clk.
- Age: age(t) = (t - rob_rdptr[4:0]) mod 32, 5-bit unsigned. A tag is younger than the branch iff age(tag) > age(cfc_robtag).
- Eligibility: eligible[i] = req_val[i] && !(cdb_flush && younger(req_robtag[i])). The branch tag itself is not younger and remains eligible.
- Grant: the first eligible index searching rr_ptr, rr_ptr+1, ... with NREQ wrap-around. At most one req_gnt bit is high. No eligible request gives req_gnt=0.
- Pointer: on any grant to index k, rr_ptr <= (k+1) mod NREQ. With no grant, rr_ptr holds.
- Handshake:
  - Requester samples req_gnt at the clock edge and drops or replaces its request the next cycle.
  - An ungranted request must stay stable.
  - A flushed, ineligible request is never granted. The requester clears itself on cdb_flush.
- Broadcast (see Optional Feature):
  - Granted fields appear on cdb_* with cdb_val=1.
  - One broadcast per cycle; back-to-back grants give a continuous broadcast stream.
- Flush of in-flight broadcast (registered mode only): if cdb_flush=1 and the registered cdb_robtag is younger, cdb_val is cleared on the next edge unless a new eligible grant replaces it.
- Simultaneous: all NREQ requesting gives one grant per cycle in rotating order; each requester is served within NREQ cycles.
- NREQ=1: rr_ptr fixed at 0; grant = eligible[0].

Optional Feature:
- Macro: CDB_OUT_REG_EN.
- Defined:
  - cdb_* outputs are registered; broadcast appears the cycle after req_gnt, giving 1-cycle latency.
  - cdb_val=0 in any cycle following no grant.
  - The in-flight flush rule applies.
- Undefined:
  - cdb_* is combinational from the granted requester in the same cycle as req_gnt, giving 0 latency.
  - When no grant, cdb_val=0 and the other cdb_* fields are 0.
  - No in-flight state exists; flush masking via eligibility alone.

Test Plan:
1. Reset then idle: rst_b=0 mid-broadcast -> cdb_val=0, req_gnt=0 immediately; after release with req_val=0, cdb_val stays 0.
2. Single request: req_val=4'b0100, tag 7, phy 6'd33, data 32'hDEADBEEF -> req_gnt=4'b0100; cdb_val=1, cdb_robtag=7, cdb_phy_addr=33, cdb_data=DEADBEEF, cdb_src=2 (next cycle with CDB_OUT_REG_EN, same cycle without).
3. Round-robin: req_val=4'b1111 held; each granted requester re-requests the cycle after its grant -> grants 0,1,2,3,0 on consecutive cycles.
4. Pointer skip: rr_ptr=1, req_val=4'b1001 -> grant 3, then grant 0 next cycle.
5. Flush mask: rob_rdptr=30, cfc_robtag=2, cdb_flush=1, req0 tag 1, req1 tag 5, both valid, rr_ptr=1 -> req1 masked (age 7 > 4), req0 granted (age 3).
6. In-flight squash (CDB_OUT_REG_EN): registered broadcast tag 9 and no new request; cdb_flush=1 with cfc_robtag=4, rob_rdptr=0 -> cdb_val=0 the next cycle.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - CDB arbiter bus bundle: requester inputs, grant and broadcast outputs
//
// Signals (NREQ requesters, SW = winner index width):
//   req_val      [NREQ]     requester i has a result ready
//   req_robtag   [NREQ*5]   ROB tag per requester
//   req_phy_addr [NREQ*6]   destination physical register per requester
//   req_data     [NREQ*32]  result data per requester
//   req_swaddr   [NREQ*32]  store word address per requester
//   req_gnt      [NREQ]     one-hot grant (combinational)
//   rob_rdptr    [6]        ROB head pointer
//   cdb_flush    [1]        branch misprediction flush
//   cfc_robtag   [5]        ROB tag of the mispredicted branch
//   cdb_val/robtag/phy_addr/data/swaddr/src   CDB broadcast
// Modports: master = requesters/ROB side, slave = arbiter.

interface cdb_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_val;
    logic [NREQ*5-1:0]  req_robtag;
    logic [NREQ*6-1:0]  req_phy_addr;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ*32-1:0] req_swaddr;
    logic [NREQ-1:0]    req_gnt;
    logic [5:0]         rob_rdptr;
    logic               cdb_flush;
    logic [4:0]         cfc_robtag;
    logic               cdb_val;
    logic [4:0]         cdb_robtag;
    logic [5:0]         cdb_phy_addr;
    logic [31:0]        cdb_data;
    logic [31:0]        cdb_swaddr;
    logic [SW-1:0]      cdb_src;

    modport master (
        output req_val, req_robtag, req_phy_addr, req_data, req_swaddr,
        output rob_rdptr, cdb_flush, cfc_robtag,
        input  req_gnt,
        input  cdb_val, cdb_robtag, cdb_phy_addr, cdb_data, cdb_swaddr, cdb_src
    );

    modport slave (
        input  req_val, req_robtag, req_phy_addr, req_data, req_swaddr,
        input  rob_rdptr, cdb_flush, cfc_robtag,
        output req_gnt,
        output cdb_val, cdb_robtag, cdb_phy_addr, cdb_data, cdb_swaddr, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin Common Data Bus arbiter with branch-flush squashing
//
// Ports:
//   clk    clock
//   rst_b  asynchronous active-low reset
//   bus    cdb_arbiter_if.slave (requests, ROB head, flush, grant, CDB broadcast)
// Build option:
//   CDB_OUT_REG_EN  defined   -> broadcast registered, one cycle after req_gnt
//                   undefined -> broadcast combinational, same cycle as req_gnt

module cdb_arbiter #(
    parameter int NREQ = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    cdb_arbiter_if.slave bus
);
    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Position of a tag relative to the ROB head; larger means younger.
    function automatic logic [4:0] age(input logic [4:0] tag, input logic [4:0] head);
        return tag - head;
    endfunction

    // (a + b) mod NREQ for a, b < NREQ, computed one bit wider to hold the carry.
    function automatic logic [SW-1:0] add_mod(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (SW+1)'(NREQ)) sum = sum - (SW+1)'(NREQ);
        return sum[SW-1:0];
    endfunction

    logic [SW-1:0]     r_rr_ptr;
    logic [4:0]        w_head;
    logic [4:0]        w_br_age;
    logic [NREQ-1:0]   w_elig;
    logic [2*NREQ-1:0] w_rot_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [SW-1:0]     w_off;
    logic              w_any;
    logic              w_fire;
    logic [SW-1:0]     w_win;
    logic [NREQ-1:0]   w_gnt;
    logic [4:0]        w_tag;
    logic [5:0]        w_phy;
    logic [31:0]       w_data;
    logic [31:0]       w_swaddr;
    logic              w_unused_rdptr_msb;

    // Only the low five bits of the head pointer take part in the age compare.
    assign w_unused_rdptr_msb = bus.rob_rdptr[5];

    assign w_head   = bus.rob_rdptr[4:0];
    assign w_br_age = age(bus.cfc_robtag, w_head);

    // The mispredicted branch itself has equal age and so stays eligible.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = bus.req_val[i] &&
                        !(bus.cdb_flush && (age(bus.req_robtag[5*i +: 5], w_head) > w_br_age));
        end
    end

    // Rotate eligibility so bit 0 is the requester at the pointer; the lowest
    // set bit is then the offset of the winner from the pointer.
    assign w_rot_dbl = {w_elig, w_elig} >> r_rr_ptr;
    assign w_rot     = w_rot_dbl[NREQ-1:0];

    always_comb begin
        w_off = '0;
        w_any = 1'b0;
        for (int o = NREQ - 1; o >= 0; o--) begin
            if (w_rot[o]) begin
                w_off = SW'(o);
                w_any = 1'b1;
            end
        end
    end

    // Grant is held off while reset is asserted even though it is combinational.
    assign w_fire = w_any && rst_b;
    assign w_win  = add_mod(r_rr_ptr, w_off);

    always_comb begin
        w_gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_gnt[i] = w_fire && (w_win == SW'(i));
        end
    end

    assign bus.req_gnt = w_gnt;

    // One-hot grant makes an OR-mux sufficient; all zero when nothing is granted.
    always_comb begin
        w_tag    = '0;
        w_phy    = '0;
        w_data   = '0;
        w_swaddr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_tag    = w_tag    | bus.req_robtag[5*i +: 5];
                w_phy    = w_phy    | bus.req_phy_addr[6*i +: 6];
                w_data   = w_data   | bus.req_data[32*i +: 32];
                w_swaddr = w_swaddr | bus.req_swaddr[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rr_ptr <= '0;
        end else if (w_fire) begin
            r_rr_ptr <= add_mod(w_win, SW'(1 % NREQ));
        end
    end

`ifdef CDB_OUT_REG_EN
    logic          r_cdb_val;
    logic [4:0]    r_cdb_robtag;
    logic [5:0]    r_cdb_phy_addr;
    logic [31:0]   r_cdb_data;
    logic [31:0]   r_cdb_swaddr;
    logic [SW-1:0] r_cdb_src;

    // Valid follows the grant directly: a cycle with no grant clears it, which
    // also squashes an in-flight broadcast that a flush made stale. A flushed
    // younger request cannot win, so any replacement is always an eligible one.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cdb_val      <= 1'b0;
            r_cdb_robtag   <= '0;
            r_cdb_phy_addr <= '0;
            r_cdb_data     <= '0;
            r_cdb_swaddr   <= '0;
            r_cdb_src      <= '0;
        end else begin
            r_cdb_val <= w_fire;
            if (w_fire) begin
                r_cdb_robtag   <= w_tag;
                r_cdb_phy_addr <= w_phy;
                r_cdb_data     <= w_data;
                r_cdb_swaddr   <= w_swaddr;
                r_cdb_src      <= w_win;
            end
        end
    end

    assign bus.cdb_val      = r_cdb_val;
    assign bus.cdb_robtag   = r_cdb_robtag;
    assign bus.cdb_phy_addr = r_cdb_phy_addr;
    assign bus.cdb_data     = r_cdb_data;
    assign bus.cdb_swaddr   = r_cdb_swaddr;
    assign bus.cdb_src      = r_cdb_src;
`else
    assign bus.cdb_val      = w_fire;
    assign bus.cdb_robtag   = w_tag;
    assign bus.cdb_phy_addr = w_phy;
    assign bus.cdb_data     = w_data;
    assign bus.cdb_swaddr   = w_swaddr;
    assign bus.cdb_src      = w_fire ? w_win : '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter

module tb_cdb_arbiter;
    localparam int NREQ = 4;

    logic clk;
    logic rst_b;
    int   checks;
    int   errors;

    cdb_arbiter_if #(.NREQ(NREQ)) bus ();

    cdb_arbiter #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bcast(input string tag, input logic [4:0] rt, input logic [5:0] phy,
                         input logic [31:0] data, input logic [31:0] sw, input logic [1:0] src);
        chk({tag, "_val"},  64'(bus.cdb_val), 64'd1);
        chk({tag, "_tag"},  64'(bus.cdb_robtag), 64'(rt));
        chk({tag, "_phy"},  64'(bus.cdb_phy_addr), 64'(phy));
        chk({tag, "_data"}, 64'(bus.cdb_data), 64'(data));
        chk({tag, "_sw"},   64'(bus.cdb_swaddr), 64'(sw));
        chk({tag, "_src"},  64'(bus.cdb_src), 64'(src));
    endtask

    task automatic set_req(input int i, input logic [4:0] rt, input logic [5:0] phy,
                           input logic [31:0] data, input logic [31:0] sw);
        bus.req_robtag[5*i +: 5]    = rt;
        bus.req_phy_addr[6*i +: 6]  = phy;
        bus.req_data[32*i +: 32]    = data;
        bus.req_swaddr[32*i +: 32]  = sw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_b            = 1'b0;
        bus.req_val      = '0;
        bus.req_robtag   = '0;
        bus.req_phy_addr = '0;
        bus.req_data     = '0;
        bus.req_swaddr   = '0;
        bus.rob_rdptr    = '0;
        bus.cdb_flush    = 1'b0;
        bus.cfc_robtag   = '0;

        // Reset state and idle after release
        step();
        step();
        rst_b = 1'b1;
        #1;
        chk("rst_gnt", 64'(bus.req_gnt), 64'd0);
        chk("rst_val", 64'(bus.cdb_val), 64'd0);
        chk("rst_src", 64'(bus.cdb_src), 64'd0);
        step();
        chk("idle_val", 64'(bus.cdb_val), 64'd0);

        // Single request from requester 2
        set_req(2, 5'd7, 6'd33, 32'hDEADBEEF, 32'h0000_1000);
        bus.req_val = 4'b0100;
        #1;
        chk("single_gnt", 64'(bus.req_gnt), 64'b0100);
`ifndef CDB_OUT_REG_EN
        bcast("single", 5'd7, 6'd33, 32'hDEADBEEF, 32'h0000_1000, 2'd2);
`endif
        step();
`ifdef CDB_OUT_REG_EN
        bcast("single", 5'd7, 6'd33, 32'hDEADBEEF, 32'h0000_1000, 2'd2);
`endif
        bus.req_val = '0;
`ifdef CDB_OUT_REG_EN
        step();
`else
        #1;
`endif
        chk("nogrant_val", 64'(bus.cdb_val), 64'd0);
        chk("nogrant_gnt", 64'(bus.req_gnt), 64'd0);

        // Reset asserted in the middle of a broadcast (pointer is 3, req0 wins)
        set_req(0, 5'd3, 6'd4, 32'h11, 32'h22);
        bus.req_val = 4'b0001;
        #1;
        chk("pre_rst_gnt", 64'(bus.req_gnt), 64'b0001);
`ifdef CDB_OUT_REG_EN
        step();
`endif
        chk("pre_rst_val", 64'(bus.cdb_val), 64'd1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("mid_rst_gnt", 64'(bus.req_gnt), 64'd0);
        chk("mid_rst_val", 64'(bus.cdb_val), 64'd0);
        chk("mid_rst_data", 64'(bus.cdb_data), 64'd0);
        step();
        bus.req_val = '0;
        rst_b = 1'b1;
        #1;
        chk("post_rst_gnt", 64'(bus.req_gnt), 64'd0);
        step();
        chk("post_rst_val", 64'(bus.cdb_val), 64'd0);

        // Round-robin with all four requesting continuously: 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 5'(10 + i), 6'(20 + i), 32'hA0 + 32'(i), 32'hB0 + 32'(i));
        end
        bus.req_val = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % 4;
            #1;
            chk("rr_gnt", 64'(bus.req_gnt), 64'(4'b0001 << e));
`ifndef CDB_OUT_REG_EN
            bcast("rr", 5'(10 + e), 6'(20 + e), 32'hA0 + 32'(e), 32'hB0 + 32'(e), 2'(e));
`endif
            step();
`ifdef CDB_OUT_REG_EN
            bcast("rr", 5'(10 + e), 6'(20 + e), 32'hA0 + 32'(e), 32'hB0 + 32'(e), 2'(e));
`endif
        end

        // Pointer now 1: requests 0 and 3 -> 3 then 0
        bus.req_val = 4'b1001;
        #1;
        chk("skip_gnt3", 64'(bus.req_gnt), 64'b1000);
`ifndef CDB_OUT_REG_EN
        chk("skip_src3", 64'(bus.cdb_src), 64'd3);
`endif
        step();
`ifdef CDB_OUT_REG_EN
        chk("skip_src3", 64'(bus.cdb_src), 64'd3);
`endif
        #1;
        chk("skip_gnt0", 64'(bus.req_gnt), 64'b0001);
`ifndef CDB_OUT_REG_EN
        chk("skip_src0", 64'(bus.cdb_src), 64'd0);
`endif
        step();
`ifdef CDB_OUT_REG_EN
        chk("skip_src0", 64'(bus.cdb_src), 64'd0);
`endif

        // Flush mask: head 30, branch tag 2 (age 4); tag 1 age 3 ok, tag 5 age 7 masked
        bus.rob_rdptr  = 6'd30;
        bus.cfc_robtag = 5'd2;
        bus.cdb_flush  = 1'b1;
        set_req(0, 5'd1, 6'd40, 32'hC0, 32'hC4);
        set_req(1, 5'd5, 6'd41, 32'hC1, 32'hC5);
        bus.req_val = 4'b0011;
        #1;
        chk("flush_gnt", 64'(bus.req_gnt), 64'b0001);
`ifndef CDB_OUT_REG_EN
        bcast("flush", 5'd1, 6'd40, 32'hC0, 32'hC4, 2'd0);
`endif
        step();
`ifdef CDB_OUT_REG_EN
        bcast("flush", 5'd1, 6'd40, 32'hC0, 32'hC4, 2'd0);
`endif

        // The branch tag itself stays eligible
        set_req(1, 5'd2, 6'd42, 32'hC2, 32'hC6);
        bus.req_val = 4'b0010;
        #1;
        chk("brtag_gnt", 64'(bus.req_gnt), 64'b0010);
        step();

        // Only a younger request under flush: nothing granted
        set_req(1, 5'd5, 6'd41, 32'hC1, 32'hC5);
        #1;
        chk("allmask_gnt", 64'(bus.req_gnt), 64'd0);
`ifndef CDB_OUT_REG_EN
        chk("allmask_val", 64'(bus.cdb_val), 64'd0);
`endif
        step();
`ifdef CDB_OUT_REG_EN
        chk("allmask_val", 64'(bus.cdb_val), 64'd0);
`endif

        // Same request once the flush drops is granted (pointer still 2)
        bus.cdb_flush = 1'b0;
        #1;
        chk("noflush_gnt", 64'(bus.req_gnt), 64'b0010);
        step();

        // Age wrap: tag 29 with head 30 is age 31 (youngest), tag 30 is age 0
        bus.cdb_flush = 1'b1;
        set_req(3, 5'd29, 6'd43, 32'hC3, 32'hC7);
        bus.req_val = 4'b1000;
        #1;
        chk("wrap_young_gnt", 64'(bus.req_gnt), 64'd0);
        set_req(3, 5'd30, 6'd43, 32'hC3, 32'hC7);
        #1;
        chk("wrap_old_gnt", 64'(bus.req_gnt), 64'b1000);
        step();
        bus.req_val   = '0;
        bus.cdb_flush = 1'b0;

        // In-flight squash: tag 9 broadcast, then flush with branch tag 4, head 0
        bus.rob_rdptr = 6'd0;
        set_req(1, 5'd9, 6'd12, 32'h99, 32'h98);
        bus.req_val = 4'b0010;
        #1;
        chk("sq_gnt", 64'(bus.req_gnt), 64'b0010);
        step();
        bus.cdb_flush  = 1'b1;
        bus.cfc_robtag = 5'd4;
        #1;
        chk("sq_masked_gnt", 64'(bus.req_gnt), 64'd0);
`ifdef CDB_OUT_REG_EN
        chk("sq_inflight_val", 64'(bus.cdb_val), 64'd1);
        chk("sq_inflight_tag", 64'(bus.cdb_robtag), 64'd9);
`else
        chk("sq_comb_val", 64'(bus.cdb_val), 64'd0);
`endif
        step();
        chk("sq_after_val", 64'(bus.cdb_val), 64'd0);
        bus.req_val   = '0;
        bus.cdb_flush = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
